decode_issue_stage: RTL and testbench

//  Decode/issue stage that produces the execute-stage operand and control bundle: src1, src2, imm, control_in, enable_ex, mem_data_read_in.

---
 rtl/decode_issue_stage_pkg.sv | 63 ++++++
 rtl/reg_file_16x32.sv | 41 ++++
 rtl/decode_issue_stage.sv | 179 +++++++++++++++++
 tb/tb_decode_issue_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_stage_pkg.sv
// Shared widths, instruction field layout, opselect encodings and FSM state
// encoding for the decode/issue stage.
package decode_issue_stage_pkg;

    localparam int unsigned INSTR_WD = 32;
    localparam int unsigned REG_WD   = 32;
    localparam int unsigned IMM_WD   = 16;
    localparam int unsigned NREGS    = 16;
    localparam int unsigned ADDR_WD  = $clog2(NREGS);
    localparam int unsigned CTRL_WD  = 7;

    localparam int unsigned OPSEL_LSB = 29;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned IMMP_BIT  = 25;
    localparam int unsigned RD_LSB    = 21;
    localparam int unsigned RS1_LSB   = 17;
    localparam int unsigned RS2_LSB   = 13;

    localparam logic [2:0] OPSEL_SHIFT     = 3'b000;
    localparam logic [2:0] OPSEL_ARITH     = 3'b001;
    localparam logic [2:0] OPSEL_MEM_WRITE = 3'b100;
    localparam logic [2:0] OPSEL_MEM_READ  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_LOAD_REQ  = 2'd2,
        ST_LOAD_WAIT = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]         opselect;
        logic [2:0]         operation;
        logic               immp_regn;
        logic [ADDR_WD-1:0] rd;
        logic [ADDR_WD-1:0] rs1;
        logic [ADDR_WD-1:0] rs2;
        logic [IMM_WD-1:0]  imm;
    } instr_fields_t;

    // rs2 and imm overlap in the encoding; immp_regn decides which one is meaningful.
    function automatic instr_fields_t decode_fields(input logic [INSTR_WD-1:0] instr);
        instr_fields_t f;
        f.opselect  = instr[OPSEL_LSB +: 3];
        f.operation = instr[OP_LSB +: 3];
        f.immp_regn = instr[IMMP_BIT];
        f.rd        = instr[RD_LSB +: ADDR_WD];
        f.rs1       = instr[RS1_LSB +: ADDR_WD];
        f.rs2       = instr[RS2_LSB +: ADDR_WD];
        f.imm       = instr[IMM_WD-1:0];
        return f;
    endfunction

    function automatic logic [REG_WD-1:0] sext_imm(input logic [IMM_WD-1:0] imm);
        return {{(REG_WD-IMM_WD){imm[IMM_WD-1]}}, imm};
    endfunction

    function automatic logic writes_rd(input logic [2:0] opselect);
        return (opselect == OPSEL_ARITH) || (opselect == OPSEL_SHIFT) ||
               (opselect == OPSEL_MEM_READ);
    endfunction

endpackage

// File: rtl/reg_file_16x32.sv
// 16x32 register file: three combinational read ports with same-cycle
// writeback bypass and one synchronous write port.
module reg_file_16x32
    import decode_issue_stage_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_WD-1:0] waddr,
    input  logic [REG_WD-1:0]  wdata,
    input  logic [ADDR_WD-1:0] raddr1,
    input  logic [ADDR_WD-1:0] raddr2,
    input  logic [ADDR_WD-1:0] raddr3,
    output logic [REG_WD-1:0]  rdata1_c,
    output logic [REG_WD-1:0]  rdata2_c,
    output logic [REG_WD-1:0]  rdata3_c
);

    logic [REG_WD-1:0] regs_q [NREGS];
    logic [REG_WD-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_c = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
    assign rdata2_c = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
    assign rdata3_c = (we && (waddr == raddr3)) ? wdata : regs_q[raddr3];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: accepts instructions, resolves register hazards with a
// pending-bit scoreboard, performs load reads and issues the execute bundle.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [INSTR_WD-1:0] instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                stall_in,
    input  logic                wb_en,
    input  logic [ADDR_WD-1:0]  wb_addr,
    input  logic [REG_WD-1:0]   wb_data,
    output logic                dmem_rd_en,
    output logic [REG_WD-1:0]   dmem_addr,
    input  logic [REG_WD-1:0]   dmem_rd_data,
    output logic [REG_WD-1:0]   src1,
    output logic [REG_WD-1:0]   src2,
    output logic [REG_WD-1:0]   imm,
    output logic [CTRL_WD-1:0]  control_in,
    output logic [REG_WD-1:0]   mem_data_read_in,
    output logic                enable_ex,
    output logic [ADDR_WD-1:0]  rd_out
);

    instr_fields_t     f;
    logic [REG_WD-1:0] rs1_val_c;
    logic [REG_WD-1:0] rs2_val_c;
    logic [REG_WD-1:0] rd_val_c;

    assign f = decode_fields(instr_in);

    reg_file_16x32 u_rf (
        .clock    (clock),
        .reset    (reset),
        .we       (wb_en),
        .waddr    (wb_addr),
        .wdata    (wb_data),
        .raddr1   (f.rs1),
        .raddr2   (f.rs2),
        .raddr3   (f.rd),
        .rdata1_c (rs1_val_c),
        .rdata2_c (rs2_val_c),
        .rdata3_c (rd_val_c)
    );

    state_e             state_q, state_d;
    logic [NREGS-1:0]   pending_q, pending_d;
    logic [REG_WD-1:0]  src1_q, src1_d;
    logic [REG_WD-1:0]  src2_q, src2_d;
    logic [REG_WD-1:0]  imm_q, imm_d;
    logic [CTRL_WD-1:0] control_q, control_d;
    logic [REG_WD-1:0]  mem_data_q, mem_data_d;
    logic [REG_WD-1:0]  dmem_addr_q, dmem_addr_d;
    logic               dmem_rd_en_q, dmem_rd_en_d;
    logic               enable_ex_q, enable_ex_d;
    logic [ADDR_WD-1:0] rd_q, rd_d;

    logic [NREGS-1:0]   wb_clear_c;
    logic               is_load_c;
    logic               is_store_c;
    logic               hazard_c;
    logic               accept_c;

    // A writeback landing this cycle clears its pending bit early enough to lift the hazard.
    always_comb begin
        wb_clear_c = '0;
        if (wb_en) begin
            wb_clear_c[wb_addr] = 1'b1;
        end
        is_load_c  = (f.opselect == OPSEL_MEM_READ);
        is_store_c = (f.opselect == OPSEL_MEM_WRITE);
        hazard_c   = (pending_q[f.rs1] & ~wb_clear_c[f.rs1])
                   | (~f.immp_regn & pending_q[f.rs2] & ~wb_clear_c[f.rs2])
                   | (is_store_c & pending_q[f.rd] & ~wb_clear_c[f.rd]);
        instr_ready = reset && (state_q == ST_IDLE) && !stall_in && !hazard_c;
        accept_c    = instr_valid && instr_ready;
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q & ~wb_clear_c;
        src1_d       = src1_q;
        src2_d       = src2_q;
        imm_d        = imm_q;
        control_d    = control_q;
        mem_data_d   = mem_data_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_rd_en_d = 1'b0;
        enable_ex_d  = 1'b0;
        rd_d         = rd_q;

        if (accept_c && writes_rd(f.opselect)) begin
            pending_d[f.rd] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    src1_d    = rs1_val_c;
                    src2_d    = is_store_c ? rd_val_c : rs2_val_c;
                    imm_d     = sext_imm(f.imm);
                    control_d = {f.operation, f.immp_regn, f.opselect};
                    rd_d      = f.rd;
                    if (is_load_c) begin
                        dmem_addr_d  = rs1_val_c + sext_imm(f.imm);
                        dmem_rd_en_d = 1'b1;
                        state_d      = ST_LOAD_REQ;
                    end else begin
                        enable_ex_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_LOAD_REQ: begin
                state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                // Read data is only valid now, so it is captured regardless of stall.
                mem_data_d  = dmem_rd_data;
                enable_ex_d = !stall_in;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A pulse seen while execute is stalled is repeated once it frees up.
                if (!stall_in) begin
                    if (enable_ex_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        enable_ex_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            imm_q        <= '0;
            control_q    <= '0;
            mem_data_q   <= '0;
            dmem_addr_q  <= '0;
            dmem_rd_en_q <= 1'b0;
            enable_ex_q  <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            imm_q        <= imm_d;
            control_q    <= control_d;
            mem_data_q   <= mem_data_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_rd_en_q <= dmem_rd_en_d;
            enable_ex_q  <= enable_ex_d;
            rd_q         <= rd_d;
        end
    end

    assign src1             = src1_q;
    assign src2             = src2_q;
    assign imm              = imm_q;
    assign control_in       = control_q;
    assign mem_data_read_in = mem_data_q;
    assign dmem_addr        = dmem_addr_q;
    assign dmem_rd_en       = dmem_rd_en_q;
    assign enable_ex        = enable_ex_q;
    assign rd_out           = rd_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: inputs change just after the falling
// edge, outputs are checked there too, the DUT samples on the rising edge.
module tb_decode_issue_stage;

    logic        clock;
    logic        reset;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        dmem_rd_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_rd_data;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [6:0]  control_in;
    logic [31:0] mem_data_read_in;
    logic        enable_ex;
    logic [3:0]  rd_out;

    int n_vec = 0;
    int n_err = 0;

    decode_issue_stage dut (
        .clock            (clock),
        .reset            (reset),
        .instr_in         (instr_in),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .stall_in         (stall_in),
        .wb_en            (wb_en),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .dmem_rd_en       (dmem_rd_en),
        .dmem_addr        (dmem_addr),
        .dmem_rd_data     (dmem_rd_data),
        .src1             (src1),
        .src2             (src2),
        .imm              (imm),
        .control_in       (control_in),
        .mem_data_read_in (mem_data_read_in),
        .enable_ex        (enable_ex),
        .rd_out           (rd_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {opselect, operation, immp_regn, rd, rs1, low17}; low17 holds rs2 at [16:13] and imm at [15:0]
    function automatic logic [31:0] mk(input logic [2:0] opsel, input logic [2:0] op,
                                       input logic immp, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [16:0] low);
        return {opsel, op, immp, rd, rs1, low};
    endfunction

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_wb(input logic [3:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc();
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        n_vec++; if (enable_ex !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", enable_ex); end
        n_vec++; if (dmem_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", dmem_rd_en); end
        n_vec++; if (src1 !== 32'h0) begin n_err++; $display("FAIL rst_src1: got %h want 0", src1); end
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_held: got %b want 0", instr_ready); end
        reset = 1'b1;
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_release: got %b want 1", instr_ready); end
    endtask

    task automatic test_arith();
        instr_in = mk(3'b001, 3'b010, 1'b1, 4'd3, 4'd1, 17'h0FFF0);
        instr_valid = 1'b1;
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL arith_ready: got %b want 1", instr_ready); end
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL arith_en: got %b want 1", enable_ex); end
        n_vec++; if (imm !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL arith_imm: got %h want ffff_fff0", imm); end
        n_vec++; if (control_in !== 7'b010_1_001) begin n_err++; $display("FAIL arith_ctrl: got %b want 0101001", control_in); end
        n_vec++; if (src1 !== 32'd5) begin n_err++; $display("FAIL arith_src1: got %h want 5", src1); end
        n_vec++; if (rd_out !== 4'd3) begin n_err++; $display("FAIL arith_rd: got %0d want 3", rd_out); end
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL arith_ready_issue: got %b want 0", instr_ready); end
        cyc();
        n_vec++; if (enable_ex !== 1'b0) begin n_err++; $display("FAIL arith_en_drop: got %b want 0", enable_ex); end
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL arith_ready_idle: got %b want 1", instr_ready); end
    endtask

    task automatic test_back_to_back();
        instr_in = mk(3'b011, 3'b001, 1'b1, 4'd0, 4'd1, 17'h00002);
        instr_valid = 1'b1;
        cyc();
        n_vec++; if ({enable_ex, instr_ready} !== 2'b10) begin n_err++; $display("FAIL b2b_c1: got %b want 10", {enable_ex, instr_ready}); end
        cyc();
        n_vec++; if ({enable_ex, instr_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_c2: got %b want 01", {enable_ex, instr_ready}); end
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL b2b_c3: got %b want 1", enable_ex); end
        n_vec++; if (imm !== 32'h2) begin n_err++; $display("FAIL b2b_imm: got %h want 2", imm); end
        cyc();
        n_vec++; if (enable_ex !== 1'b0) begin n_err++; $display("FAIL b2b_c4: got %b want 0", enable_ex); end
    endtask

    task automatic test_load();
        instr_in = mk(3'b101, 3'b000, 1'b1, 4'd4, 4'd2, 17'h00008);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (dmem_rd_en !== 1'b1) begin n_err++; $display("FAIL ld_rd_en: got %b want 1", dmem_rd_en); end
        n_vec++; if (dmem_addr !== 32'h108) begin n_err++; $display("FAIL ld_addr: got %h want 108", dmem_addr); end
        n_vec++; if (enable_ex !== 1'b0) begin n_err++; $display("FAIL ld_en_early: got %b want 0", enable_ex); end
        cyc();
        n_vec++; if (dmem_rd_en !== 1'b0) begin n_err++; $display("FAIL ld_rd_en_pulse: got %b want 0", dmem_rd_en); end
        dmem_rd_data = 32'hDEAD_BEEF;
        cyc();
        dmem_rd_data = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL ld_en: got %b want 1", enable_ex); end
        n_vec++; if (mem_data_read_in !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ld_data: got %h want deadbeef", mem_data_read_in); end
        n_vec++; if (rd_out !== 4'd4) begin n_err++; $display("FAIL ld_rd: got %0d want 4", rd_out); end
        cyc();
        // address add wraps past 2^32
        do_wb(4'd6, 32'hFFFF_FFF8);
        instr_in = mk(3'b101, 3'b000, 1'b1, 4'd12, 4'd6, 17'h00010);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (dmem_addr !== 32'h8) begin n_err++; $display("FAIL ld_wrap_addr: got %h want 8", dmem_addr); end
        repeat (3) cyc();
    endtask

    task automatic test_hazard();
        instr_in = mk(3'b001, 3'b000, 1'b1, 4'd5, 4'd1, 17'h00001);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        cyc();
        instr_in = mk(3'b001, 3'b000, 1'b1, 4'd9, 4'd5, 17'h00000);
        instr_valid = 1'b1;
        #1;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL haz_block: got %b want 0", instr_ready); end
        cyc();
        n_vec++; if ({instr_ready, enable_ex} !== 2'b00) begin n_err++; $display("FAIL haz_hold: got %b want 00", {instr_ready, enable_ex}); end
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h66;
        #1;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL haz_other_wb: got %b want 0", instr_ready); end
        wb_addr = 4'd5; wb_data = 32'h1234;
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL haz_wb_release: got %b want 1", instr_ready); end
        cyc();
        wb_en = 1'b0; instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL haz_en: got %b want 1", enable_ex); end
        n_vec++; if (src1 !== 32'h1234) begin n_err++; $display("FAIL haz_bypass: got %h want 1234", src1); end
        cyc();
    endtask

    task automatic test_rs2_hazard();
        // R9 is pending here; rs2 field = 9
        instr_in = mk(3'b011, 3'b000, 1'b0, 4'd0, 4'd1, 17'h12000);
        #1;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rs2_reg_haz: got %b want 0", instr_ready); end
        instr_in = mk(3'b011, 3'b000, 1'b1, 4'd0, 4'd1, 17'h12000);
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rs2_imm_nohaz: got %b want 1", instr_ready); end
        instr_in = mk(3'b100, 3'b000, 1'b1, 4'd9, 4'd1, 17'h00004);
        #1;
        n_vec++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL st_rd_haz: got %b want 0", instr_ready); end
        instr_in = 32'h0;
    endtask

    task automatic test_store();
        instr_in = mk(3'b100, 3'b000, 1'b1, 4'd7, 4'd1, 17'h00004);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (src2 !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL st_src2: got %h want a5a5a5a5", src2); end
        n_vec++; if ({enable_ex, dmem_rd_en} !== 2'b10) begin n_err++; $display("FAIL st_issue: got %b want 10", {enable_ex, dmem_rd_en}); end
        cyc();
        instr_in = mk(3'b001, 3'b000, 1'b1, 4'd0, 4'd7, 17'h00000);
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL st_no_pending: got %b want 1", instr_ready); end
        instr_in = 32'h0;
    endtask

    task automatic test_stall();
        int pulses;
        instr_in = mk(3'b011, 3'b101, 1'b1, 4'd10, 4'd1, 17'h00077);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL stall_first: got %b want 1", enable_ex); end
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (enable_ex !== 1'b0) begin n_err++; $display("FAIL stall_en_c%0d: got %b want 0", i, enable_ex); end
            n_vec++; if ({src1, imm, control_in, rd_out} !== {32'd5, 32'h77, 7'b101_1_011, 4'd10}) begin
                n_err++; $display("FAIL stall_bundle_c%0d: got %h %h %b %0d want 5 77 1011011 10", i, src1, imm, control_in, rd_out);
            end
        end
        stall_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (enable_ex === 1'b1) pulses++;
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
        n_vec++; if (src1 !== 32'd5) begin n_err++; $display("FAIL stall_src1_end: got %h want 5", src1); end
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_end: got %b want 1", instr_ready); end
    endtask

    task automatic test_reset_mid_load();
        instr_in = mk(3'b101, 3'b000, 1'b1, 4'd11, 4'd2, 17'h00010);
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (dmem_addr !== 32'h110) begin n_err++; $display("FAIL rml_addr: got %h want 110", dmem_addr); end
        cyc();
        dmem_rd_data = 32'hCAFE_0000;
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({src1, imm, dmem_addr, mem_data_read_in} !== 128'h0) begin
            n_err++; $display("FAIL rml_data_clr: got %h %h %h %h want all 0", src1, imm, dmem_addr, mem_data_read_in);
        end
        n_vec++; if ({control_in, rd_out, enable_ex, dmem_rd_en, instr_ready} !== 14'h0) begin
            n_err++; $display("FAIL rml_ctl_clr: got %b %0d %b %b %b want all 0", control_in, rd_out, enable_ex, dmem_rd_en, instr_ready);
        end
        @(negedge clock);
        reset = 1'b1; dmem_rd_data = 32'h0;
        // R9 was pending before reset; rs2 = R1 which held 5 before reset
        instr_in = mk(3'b011, 3'b000, 1'b0, 4'd0, 4'd9, 17'h02000);
        #1;
        n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rml_ready: got %b want 1", instr_ready); end
        cyc();
        n_vec++; if ({enable_ex, dmem_rd_en} !== 2'b00) begin n_err++; $display("FAIL rml_stale: got %b want 00", {enable_ex, dmem_rd_en}); end
        instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0; instr_in = 32'h0;
        n_vec++; if (enable_ex !== 1'b1) begin n_err++; $display("FAIL rml_issue: got %b want 1", enable_ex); end
        n_vec++; if (src2 !== 32'h0) begin n_err++; $display("FAIL rml_rf_clr: got %h want 0", src2); end
        cyc();
    endtask

    initial begin
        reset = 1'b0;
        instr_in = 32'h0; instr_valid = 1'b0; stall_in = 1'b0;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'h0; dmem_rd_data = 32'h0;
        test_reset();
        do_wb(4'd1, 32'd5);
        do_wb(4'd2, 32'h100);
        do_wb(4'd7, 32'hA5A5_A5A5);
        test_arith();
        test_back_to_back();
        test_load();
        test_hazard();
        test_rs2_hazard();
        test_store();
        test_stall();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
